// File: rtl/chip8_fetch_unit.sv
// Chip-8 instruction fetch stage: owns PC and return stack, assembles big-endian
// opcodes from byte-wide program memory and hands them to the decoder.
module chip8_fetch_unit #(
    parameter int                ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] RESET_PC    = 'h200,
    parameter int                STACK_DEPTH = 16
) (
    input  logic              cpu_clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic [2:0]        pc_cmd,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [ADDR_W-1:0] pc,
    output logic [4:0]        sp,
    output logic              fault,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_REQ_HI = 3'd0,
        S_REQ_LO = 3'd1,
        S_CAP_LO = 3'd2,
        S_VALID  = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam int                SPW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0]        DEPTH = 5'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [4:0]        sp_q, sp_d;
    logic              fault_q, fault_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              push;
    logic [SPW-1:0]    top_idx;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    assign top_idx = sp_q[SPW-1:0] - SPW'(1);

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state_q <= S_REQ_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: an opcode transfers on a rising edge where instr_valid && instr_ready;
    // pc_cmd/pc_target are only looked at on that edge, and ready without valid is ignored.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        fault_d = fault_q;
        instr_d = instr_q;
        push    = 1'b0;
        case (state_q)
            S_REQ_HI: state_d = S_REQ_LO;
            S_REQ_LO: begin
                instr_d[15:8] = mem_rdata;
                state_d       = S_CAP_LO;
            end
            S_CAP_LO: begin
                instr_d[7:0] = mem_rdata;
                state_d      = S_VALID;
            end
            S_VALID: begin
                if (instr_ready) begin
                    state_d = S_REQ_HI;
                    case (pc_cmd)
                        3'd1: pc_d = pc_q + FOUR;
                        3'd2: pc_d = pc_target;
                        3'd3: begin
                            if (sp_q < DEPTH) begin
                                push = 1'b1;
                                sp_d = sp_q + 5'd1;
                                pc_d = pc_target;
                            end else begin
                                fault_d = 1'b1;
                                state_d = S_FAULT;
                            end
                        end
                        3'd4: begin
                            if (sp_q != 5'd0) begin
                                sp_d = sp_q - 5'd1;
                                pc_d = stack_q[top_idx];
                            end else begin
                                fault_d = 1'b1;
                                state_d = S_FAULT;
                            end
                        end
                        default: pc_d = pc_q + TWO;
                    endcase
                end
            end
            default: state_d = S_FAULT;
        endcase
    end

    // The memory strobe is masked during reset so an in-flight request never issues.
    always_comb begin
        mem_re      = 1'b0;
        mem_addr    = addr_q;
        instr_valid = 1'b0;
        if (reset) begin
            mem_addr = '0;
        end else begin
            case (state_q)
                S_REQ_HI: begin
                    mem_re   = 1'b1;
                    mem_addr = pc_q;
                end
                S_REQ_LO: begin
                    mem_re   = 1'b1;
                    mem_addr = pc_q + ONE;
                end
                S_VALID: instr_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            sp_q    <= 5'd0;
            fault_q <= 1'b0;
            instr_q <= 16'h0000;
            addr_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
            instr_q <= instr_d;
            addr_q  <= mem_addr;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset && push) begin
            stack_q[sp_q[SPW-1:0]] <= pc_q + TWO;
        end
    end

    assign instruction = instr_q;
    assign pc          = pc_q;
    assign sp          = sp_q;
    assign fault       = fault_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_chip8_fetch_unit.sv
// Bench for chip8_fetch_unit: timeline/stack model checked every cycle, plus
// directed sequences with literal expectations.
module tb_chip8_fetch_unit;

  logic        cpu_clk;
  logic        reset;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  pc_cmd;
  logic [11:0] pc_target;
  logic [11:0] pc;
  logic [4:0]  sp;
  logic        fault;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [4096];

  chip8_fetch_unit dut (
    .cpu_clk     (cpu_clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_cmd      (pc_cmd),
    .pc_target   (pc_target),
    .pc          (pc),
    .sp          (sp),
    .fault       (fault),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // program memory: data valid the cycle after the strobe
  always @(posedge cpu_clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: cycles since fetch start, pc, stack as a queue
  logic        m_known = 1'b0;
  logic [11:0] m_pc;
  logic [11:0] m_stk[$];
  logic        m_fault;
  int          m_cnt;

  always @(posedge cpu_clk) begin
    if (reset) begin
      m_known = 1'b1;
      m_pc    = 12'h200;
      m_stk.delete();
      m_fault = 1'b0;
      m_cnt   = 0;
    end else if (m_known && !m_fault) begin
      if (m_cnt < 3) begin
        m_cnt++;
      end else if (instr_ready) begin
        m_cnt = 0;
        case (pc_cmd)
          3'd1: m_pc = m_pc + 12'd4;
          3'd2: m_pc = pc_target;
          3'd3: begin
            if (m_stk.size() < 16) begin
              m_stk.push_back(m_pc + 12'd2);
              m_pc = pc_target;
            end else m_fault = 1'b1;
          end
          3'd4: begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else m_fault = 1'b1;
          end
          default: m_pc = m_pc + 12'd2;
        endcase
      end
    end
  end

  // scoreboard compare, away from the active edge
  logic        exp_valid;
  logic [11:0] m_pc1;
  always @(negedge cpu_clk) begin
    if (m_known) begin
      if (reset) begin
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
      end else begin
        exp_valid = !m_fault && (m_cnt == 3);
        m_pc1 = m_pc + 12'd1;
        check("m_valid", 32'(instr_valid), 32'(exp_valid));
        check("m_pc", 32'(pc), 32'(m_pc));
        check("m_sp", 32'(sp), 32'(m_stk.size()));
        check("m_fault", 32'(fault), 32'(m_fault));
        check("m_mem_re", 32'(mem_re), 32'(!m_fault && m_cnt < 2));
        if (!m_fault && m_cnt == 0) check("m_addr_hi", 32'(mem_addr), 32'(m_pc));
        if (!m_fault && m_cnt == 1) check("m_addr_lo", 32'(mem_addr), 32'(m_pc1));
        if (exp_valid) check("m_instr", 32'(instruction), {16'h0, mem[m_pc], mem[m_pc1]});
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    reset = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20) begin
      @(posedge cpu_clk); #1;
      n++;
      if (instr_valid) break;
    end
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: instr_valid=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [11:0] tgt);
    pc_cmd      = cmd;
    pc_target   = tgt;
    instr_ready = 1'b1;
    @(posedge cpu_clk); #1;
    instr_ready = 1'b0;
    pc_cmd      = 3'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'h200);
    check({tag, "_sp"}, 32'(sp), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
    check({tag, "_instr"}, 32'(instruction), 32'd0);
  endtask

  int n;

  initial begin
    reset       = 1'b1;
    instr_ready = 1'b0;
    pc_cmd      = 3'd0;
    pc_target   = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 8'h3C);
    mem[12'h200] = 8'h6A; mem[12'h201] = 8'h05;
    mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;

    // first fetch latency and back-to-back rate
    instr_ready = 1'b1;
    do_reset();
    check_reset_state("rst0");
    wait_valid(n);
    check("first_latency", 32'(n), 32'd3);
    check("first_instr", 32'(instruction), 32'h6A05);
    check("first_pc", 32'(pc), 32'h200);
    wait_valid(n);
    instr_ready = 1'b0;
    check("next_latency", 32'(n), 32'd4);
    check("next_pc", 32'(pc), 32'h202);

    // stall for 10 cycles, then SKIP
    do_reset();
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      @(posedge cpu_clk); #1;
      check("hold_instr", 32'(instruction), 32'h6A05);
      check("hold_pc", 32'(pc), 32'h200);
      check("hold_re", 32'(mem_re), 32'd0);
      check("hold_valid", 32'(instr_valid), 32'd1);
    end
    issue(3'd1, 12'h000);
    wait_valid(n);
    check("skip_pc", 32'(pc), 32'h204);

    // JUMP, CALL, RET
    issue(3'd2, 12'h300); wait_valid(n);
    check("jump_pc", 32'(pc), 32'h300);
    check("jump_sp", 32'(sp), 32'd0);
    issue(3'd3, 12'h400); wait_valid(n);
    check("call_pc", 32'(pc), 32'h400);
    check("call_sp", 32'(sp), 32'd1);
    issue(3'd4, 12'h000); wait_valid(n);
    check("ret_pc", 32'(pc), 32'h302);
    check("ret_sp", 32'(sp), 32'd0);

    // wraparound
    issue(3'd2, 12'hFFE); wait_valid(n);
    issue(3'd0, 12'h000); wait_valid(n);
    check("wrap_next_pc", 32'(pc), 32'h000);
    issue(3'd2, 12'hFFE); wait_valid(n);
    issue(3'd1, 12'h000); wait_valid(n);
    check("wrap_skip_pc", 32'(pc), 32'h002);
    issue(3'd2, 12'hFFF);
    check("fff_addr_hi", 32'(mem_addr), 32'hFFF);
    @(posedge cpu_clk); #1;
    check("fff_addr_lo", 32'(mem_addr), 32'h000);
    check("fff_re_lo", 32'(mem_re), 32'd1);
    wait_valid(n);
    check("fff_instr", 32'(instruction), 32'hABCD);

    // reset in the middle of a fetch
    issue(3'd0, 12'h000);
    @(posedge cpu_clk); #1;
    check("mid_state", 32'(dbg_state), 32'd1);
    do_reset();
    check_reset_state("rst_mid");

    // stack overflow
    for (int i = 0; i < 16; i++) begin
      wait_valid(n);
      issue(3'd3, 12'h500 + 12'(i * 16));
    end
    wait_valid(n);
    check("full_sp", 32'(sp), 32'd16);
    check("full_pc", 32'(pc), 32'h5F0);
    issue(3'd3, 12'h700);
    check("ovf_fault", 32'(fault), 32'd1);
    check("ovf_pc", 32'(pc), 32'h5F0);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge cpu_clk); #1;
      check("ovf_valid", 32'(instr_valid), 32'd0);
      check("ovf_sticky", 32'(fault), 32'd1);
    end
    instr_ready = 1'b0;
    do_reset();
    check_reset_state("rst_fault");

    // stack underflow
    wait_valid(n);
    issue(3'd4, 12'h000);
    check("unf_fault", 32'(fault), 32'd1);
    check("unf_valid", 32'(instr_valid), 32'd0);
    repeat (3) @(posedge cpu_clk);
    #1;
    do_reset();
    check_reset_state("rst_unf");
    wait_valid(n);
    check("post_unf_pc", 32'(pc), 32'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_fetch_unit.md
Name: chip8_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the Chip-8 CPU decode block.
- Owns the program counter and the 16-entry return-address stack.
- Reads two consecutive bytes from the byte-wide program memory and assembles one big-endian 16-bit opcode.
- Presents the opcode to the decoder with a valid/ready handshake.
- Applies the decoder's PC command (next/skip/jump/call/return) when the handshake completes.

Parameters:
- RESET_PC, 12'h200, PC value loaded on reset (program start).
- STACK_DEPTH, 16, return-stack entries; must be a power of 2, at most 16.
- ADDR_W, 12, memory address width; all PC arithmetic is mod 2^ADDR_W.

Ports:
- cpu_clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Synchronous reset, active high.
- mem_addr  out  ADDR_W  Byte address to program memory.
- mem_re  out  1  Read strobe; mem_rdata is valid on the cycle after mem_re=1.
- mem_rdata  in  8  Read data from program memory.
- instruction  out  16  Assembled opcode: {byte@pc, byte@pc+1}.
- instr_valid  out  1  instruction and pc are valid.
- instr_ready  in  1  Decoder accepts the current instruction.
- pc_cmd  in  3  0=NEXT, 1=SKIP, 2=JUMP, 3=CALL, 4=RET; 5-7 are treated as NEXT.
- pc_target  in  ADDR_W  Target address for JUMP and CALL.
- pc  out  ADDR_W  Address of the presented instruction.
- sp  out  5  Current stack occupancy, 0..STACK_DEPTH.
- fault  out  1  Sticky stack overflow/underflow flag.

Behaviour:
- Reset (synchronous, any state, including mid-fetch):
  - pc=RESET_PC, sp=0, fault=0, instruction=16'h0000, instr_valid=0, mem_re=0, mem_addr=0.
  - FSM goes to S_REQ_HI; any in-flight read is discarded.
  - Stack contents are don't-care.
- FSM states: S_REQ_HI, S_REQ_LO, S_CAP_LO, S_VALID, S_FAULT.
  - S_REQ_HI: mem_re=1, mem_addr=pc. Next state S_REQ_LO.
  - S_REQ_LO: mem_re=1, mem_addr=pc+1 (wraps 0xFFF->0x000); instruction[15:8]<=mem_rdata. Next state S_CAP_LO.
  - S_CAP_LO: mem_re=0; instruction[7:0]<=mem_rdata. Next state S_VALID.
  - S_VALID: instr_valid=1; instruction and pc are held stable until instr_valid&&instr_ready.
    - On that handshake edge, apply pc_cmd (below) and go to S_REQ_HI, or to S_FAULT on a stack error.
    - instr_valid deasserts the cycle after the handshake.
    - instr_ready while not valid is ignored.
  - S_FAULT: instr_valid=0, mem_re=0, fault=1. Exits only on reset.
- Timing:
  - instr_valid rises 3 cycles after entering S_REQ_HI.
  - Minimum 4 cycles per instruction when instr_ready is held at 1.
- PC commands (pc_cmd and pc_target sampled only on the handshake edge):
  - NEXT: pc<=pc+2.
  - SKIP: pc<=pc+4.
  - JUMP: pc<=pc_target.
  - CALL:
    - If sp<STACK_DEPTH: stack[sp]<=pc+2, sp<=sp+1, pc<=pc_target.
    - Else (full): fault<=1, pc and sp unchanged, go to S_FAULT.
  - RET:
    - If sp>0: pc<=stack[sp-1], sp<=sp-1.
    - Else (empty): fault<=1, go to S_FAULT.
  - All additions truncate to ADDR_W (0xFFE+2=0x000, 0xFFE+4=0x002).
- Stack:
  - Synchronous write, combinational read of the top entry.
  - Pushes and pops occur only on the handshake edge, so a push and a pop never coincide.
  - After STACK_DEPTH consecutive CALLs, sp=STACK_DEPTH and the next CALL faults.
- mem_addr holds its last value whenever mem_re=0.

Test Plan:
- Reset, memory 0x200=0x6A, 0x201=0x05, instr_ready=1, pc_cmd=NEXT -> instr_valid first high 3 cycles after reset release, instruction=16'h6A05, pc=0x200; next instruction presented with pc=0x202 exactly 4 cycles later.
- Hold instr_ready=0 for 10 cycles in S_VALID -> instruction and pc stable, mem_re=0 throughout; assert ready with pc_cmd=SKIP -> next pc=0x204.
- JUMP to 0x300, CALL to 0x400 from 0x300, then RET -> pc sequence 0x300, 0x400, 0x302; sp goes 0->1->0.
- 16 nested CALLs, then a 17th CALL -> sp=16; fault=1 and instr_valid stays 0 until reset. Separately, RET with sp=0 -> fault=1.
- pc=0xFFE with NEXT -> pc=0x000. A fetch at pc=0xFFF -> second read at mem_addr=0x000.
- Assert reset during S_REQ_LO, and again in S_FAULT -> on the following cycle pc=0x200, sp=0, fault=0, instr_valid=0, FSM in S_REQ_HI.
